// File: rtl/reg_file_mp_pkg.sv
// Shared constants, sweep FSM state type and log2 helper for reg_file_mp.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (write-to-read bypass).
package reg_file_mp_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_ZERO_REG = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: array mux, optional same-cycle bypass,
// zero-register and busy masking (bypass under REG_FILE_MP_BYPASS_EN).
module reg_file_mp_rd_port
   import reg_file_mp_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int ZERO_REG = DEF_ZERO_REG,
   localparam int ADDR_W   = clog2(DEPTH)
) (
   input  logic [ADDR_W-1:0]       raddr_i,
   input  logic [DEPTH*DATA_W-1:0] regs_i,
`ifdef REG_FILE_MP_BYPASS_EN
   input  logic [1:0]              we_i,
   input  logic [2*ADDR_W-1:0]     waddr_i,
   input  logic [2*DATA_W-1:0]     wdata_i,
`endif
   input  logic                    busy_i,
   output logic [DATA_W-1:0]       rdata_o
);

   always_comb begin
      rdata_o = regs_i[raddr_i*DATA_W +: DATA_W];
`ifdef REG_FILE_MP_BYPASS_EN
      // port 1 checked last so it wins a same-address double write
      if (we_i[0] && waddr_i[0 +: ADDR_W] == raddr_i)
         rdata_o = wdata_i[0 +: DATA_W];
      if (we_i[1] && waddr_i[ADDR_W +: ADDR_W] == raddr_i)
         rdata_o = wdata_i[DATA_W +: DATA_W];
`endif
      if (busy_i || (ZERO_REG != 0 && raddr_i == '0))
         rdata_o = '0;
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD read ports, 2 write ports, clear sweep.
// Optional REG_FILE_MP_BYPASS_EN forwards same-cycle writes to reads.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NUM_RD   = DEF_NUM_RD,
   parameter  int ZERO_REG = DEF_ZERO_REG,
   localparam int ADDR_W   = clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
   output logic [NUM_RD*DATA_W-1:0] ReadData,
   input  logic [1:0]               WriteEnable,
   input  logic [2*ADDR_W-1:0]      WriteRegister,
   input  logic [2*DATA_W-1:0]      WriteData,
   output logic                     Busy
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH*DATA_W-1:0] regs_flat;
   logic [1:0]        wr_en;
   logic [ADDR_W-1:0] wa0, wa1;

   assign wa0 = WriteRegister[0 +: ADDR_W];
   assign wa1 = WriteRegister[ADDR_W +: ADDR_W];

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (rst) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            CLEAR: begin
               if (cnt_q == LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RUN: ;
            default: state_d = CLEAR;
         endcase
      end
   end

   always_comb begin
      Busy = rst || (state_q == CLEAR);
   end

   // writes only land in RUN, so they never collide with the sweep
   always_comb begin
      wr_en[0] = WriteEnable[0] && !Busy &&
                 !(ZERO_REG != 0 && wa0 == '0);
      wr_en[1] = WriteEnable[1] && !Busy &&
                 !(ZERO_REG != 0 && wa1 == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q == CLEAR)
         regs_q[cnt_q] <= '0;
      if (wr_en[0])
         regs_q[wa0] <= WriteData[0 +: DATA_W];
      if (wr_en[1])
         regs_q[wa1] <= WriteData[DATA_W +: DATA_W];
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      reg_file_mp_rd_port #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .raddr_i (ReadRegister[k*ADDR_W +: ADDR_W]),
         .regs_i  (regs_flat),
`ifdef REG_FILE_MP_BYPASS_EN
         .we_i    (wr_en),
         .waddr_i (WriteRegister),
         .wdata_i (WriteData),
`endif
         .busy_i  (Busy),
         .rdata_o (ReadData[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: ZERO_REG=1 and ZERO_REG=0 instances.
// Expected values come from an array/countdown model of the register file.
module tb_reg_file_mp;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  ReadRegister;
   logic [63:0] rd0, rd1;
   logic [1:0]  WriteEnable;
   logic [9:0]  WriteRegister;
   logic [63:0] WriteData;
   logic        busy0, busy1;

   always #5 clk = ~clk;

   reg_file_mp #(.ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .ReadRegister(ReadRegister), .ReadData(rd0),
      .WriteEnable(WriteEnable), .WriteRegister(WriteRegister),
      .WriteData(WriteData), .Busy(busy0)
   );

   reg_file_mp #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst),
      .ReadRegister(ReadRegister), .ReadData(rd1),
      .WriteEnable(WriteEnable), .WriteRegister(WriteRegister),
      .WriteData(WriteData), .Busy(busy1)
   );

   typedef struct {
      int          cyc;
      int          inst;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          cyc_n = 0;
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] mem [2][DEPTH];
   int          left = DEPTH;

   always @(posedge clk) cyc_n++;

   exp_t        t;
   logic [31:0] act;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
         t = sb.pop_front();
         if (t.port < 0)
            act = {31'b0, (t.inst == 1) ? busy1 : busy0};
         else
            act = (t.inst == 1) ? rd1[t.port*32 +: 32] : rd0[t.port*32 +: 32];
         n_chk++;
         if (t.cyc != cyc_n || act !== t.exp) begin
            n_err++;
            $display("FAIL %s inst%0d port%0d cyc%0d: got %h want %h",
                     (t.port < 0) ? "busy" : "rdata", t.inst, t.port,
                     t.cyc, act, t.exp);
         end
      end
   end

   task automatic step(input logic r, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1);
      logic        b;
      logic [4:0]  ra [2];
      logic [31:0] e;
      @(posedge clk);
      #1;
      rst           = r;
      WriteEnable   = we;
      WriteRegister = {wa1, wa0};
      WriteData     = {wd1, wd0};
      ReadRegister  = {ra1, ra0};
      ra[0] = ra0;
      ra[1] = ra1;
      b = r || (left > 0);
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{cyc_n, i, -1, {31'b0, b}});
         for (int k = 0; k < 2; k++) begin
            e = mem[i][ra[k]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (we[0] && wa0 == ra[k]) e = wd0;
            if (we[1] && wa1 == ra[k]) e = wd1;
`endif
            if (b || (i == 0 && ra[k] == 5'd0)) e = '0;
            sb.push_back('{cyc_n, i, k, e});
         end
      end
      if (r) begin
         left = DEPTH;
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < DEPTH; a++) mem[i][a] = '0;
      end else begin
         if (!b) begin
            for (int i = 0; i < 2; i++) begin
               if (we[0] && !(i == 0 && wa0 == 5'd0)) mem[i][wa0] = wd0;
               if (we[1] && !(i == 0 && wa1 == 5'd0)) mem[i][wa1] = wd1;
            end
         end
         if (left > 0) left--;
      end
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0,
           5'($urandom), 5'($urandom));
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, a0, a1);
   endtask

   initial begin
      rst = 1'b1;
      WriteEnable = '0;
      WriteRegister = '0;
      WriteData = '0;
      ReadRegister = '0;
      for (int i = 0; i < 2; i++)
         for (int a = 0; a < DEPTH; a++) mem[i][a] = 'x;

      step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd0);
      repeat (DEPTH) idle();
      for (int a = 0; a < DEPTH; a += 2) rd(5'(a), 5'(a + 1));

      step(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd1, 5'd2);
      rd(5'd5, 5'd5);

      step(1'b0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd0, 5'd0);
      rd(5'd7, 5'd7);
      step(1'b0, 2'b11, 5'd3, 32'h3333, 5'd4, 32'h4444, 5'd0, 5'd0);
      rd(5'd3, 5'd4);

      step(1'b0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 5'd1, 5'd1);
      rd(5'd0, 5'd0);
      step(1'b0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
      rd(5'd0, 5'd7);

      step(1'b0, 2'b01, 5'd2, 32'h33, 5'd0, 32'd0, 5'd0, 5'd0);
      step(1'b0, 2'b01, 5'd2, 32'hA5, 5'd0, 32'd0, 5'd2, 5'd2);
      rd(5'd2, 5'd2);

      step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
      repeat (10) idle();
      step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
      step(1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 5'd9, 5'd9);
      repeat (DEPTH - 1) idle();
      rd(5'd9, 5'd5);

      repeat (400)
         step(($urandom_range(0, 199) == 0), 2'($urandom),
              5'($urandom), $urandom, 5'($urandom), $urandom,
              5'($urandom), 5'($urandom));
      repeat (DEPTH + 2) idle();

      repeat (2) @(posedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
